// File: rtl/temperature_ctrl_pkg.sv
// Shared types and constants for the temperature sequencing controller.
// Zone/state encodings, config addresses, reset thresholds, saturating subtract.
package temperature_pkg;

   typedef enum logic [1:0] {
      ZONE_NORMAL = 2'd0,
      ZONE_WARN   = 2'd1,
      ZONE_ALARM  = 2'd2
   } zone_e;

   typedef enum logic [1:0] {
      WAIT = 2'd0,
      REQ  = 2'd1,
      EVAL = 2'd2
   } state_e;

   localparam logic [1:0] CFG_WARN  = 2'd0;
   localparam logic [1:0] CFG_ALARM = 2'd1;
   localparam logic [1:0] CFG_CLEAR = 2'd2;

   localparam logic [7:0] WARN_TH_RST  = 8'd60;
   localparam logic [7:0] ALARM_TH_RST = 8'd80;

   // a - b clamped at zero; any b above 255 clamps to zero as well
   function automatic logic [7:0] sat_sub(input logic [7:0] a, input int unsigned b);
      logic [8:0] diff;
      if (b > 32'd255) return '0;
      diff = {1'b0, a} - b[8:0];
      return diff[8] ? '0 : diff[7:0];
   endfunction

endpackage

// File: rtl/temperature_ctrl_if.sv
// Sensor handshake and configuration bus between the sensor/software side
// (master) and the temperature controller (slave).
interface temperature_ctrl_if;
   logic       raw_valid;
   logic [7:0] raw_data;
   logic       raw_ready;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [7:0] cfg_wdata;

   modport master (
      output raw_valid, raw_data, cfg_we, cfg_addr, cfg_wdata,
      input  raw_ready
   );

   modport slave (
      input  raw_valid, raw_data, cfg_we, cfg_addr, cfg_wdata,
      output raw_ready
   );
endinterface

// File: rtl/temperature_ctrl_zone_eval.sv
// Combinational hysteresis classifier: next zone from current zone and new average.
module temperature_zone_eval
   import temperature_pkg::*;
#(
   parameter int unsigned HYST = 2
) (
   input  zone_e      zone_cur,
   input  logic [7:0] avg,
   input  logic [7:0] warn_th,
   input  logic [7:0] alarm_th,
   output zone_e      zone_nxt
);

   logic [7:0] warn_lo;
   logic [7:0] alarm_lo;
   zone_e      rise;

   assign warn_lo  = sat_sub(warn_th, HYST);
   assign alarm_lo = sat_sub(alarm_th, HYST);

   // Rising is only taken when it lands above the current zone, so an ALARM
   // average sitting between warn_th and alarm_th falls under hysteresis instead.
   always_comb begin
      rise     = ZONE_NORMAL;
      zone_nxt = zone_cur;
      if (avg >= alarm_th) begin
         rise = ZONE_ALARM;
      end else if (avg >= warn_th) begin
         rise = ZONE_WARN;
      end
      if (rise > zone_cur) begin
         zone_nxt = rise;
      end else begin
         case (zone_cur)
            ZONE_ALARM: if (avg < alarm_lo) zone_nxt = (avg >= warn_lo) ? ZONE_WARN : ZONE_NORMAL;
            ZONE_WARN:  if (avg < warn_lo) zone_nxt = ZONE_NORMAL;
            default:    zone_nxt = zone_cur;
         endcase
      end
   end

endmodule

// File: rtl/temperature_ctrl.sv
// Periodic sensor sampler: pulls raw codes, averages converted samples and
// classifies the average into NORMAL/WARN/ALARM with hysteresis.
module temperature_ctrl
   import temperature_pkg::*;
#(
   parameter int unsigned SAMPLE_PERIOD = 100,
   parameter int unsigned AVG_LOG2      = 2,
   parameter int unsigned HYST          = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   temperature_ctrl_if.slave  bus,
   output logic [7:0]         conv_in,
   input  logic [7:0]         conv_out,
   output logic               temp_valid,
   output logic [7:0]         temp_avg,
   output logic [1:0]         zone,
   output logic               warn,
   output logic               alarm
);

   localparam int unsigned CW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int unsigned SW = 8 + AVG_LOG2;
   localparam int unsigned NW = AVG_LOG2 + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_PERIOD - 1);
   localparam logic [NW-1:0] N_FULL   = NW'(1 << AVG_LOG2);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [NW-1:0] num_q, num_d;
   logic [SW-1:0] sum_q, sum_d;
   logic [7:0]    warn_th_q, warn_th_d;
   logic [7:0]    alarm_th_q, alarm_th_d;
   logic [7:0]    temp_avg_q, temp_avg_d;
   logic          temp_valid_q, temp_valid_d;
   zone_e         zone_q, zone_d;
   zone_e         zone_nx;
   logic [7:0]    avg_new;
   logic          hs;

   assign conv_in       = bus.raw_data;
   assign bus.raw_ready = (state_q == REQ) && enable;
   assign hs            = bus.raw_valid && bus.raw_ready;
   assign avg_new       = 8'(sum_q >> AVG_LOG2);

   temperature_zone_eval #(.HYST(HYST)) u_zone_eval (
      .zone_cur (zone_q),
      .avg      (avg_new),
      .warn_th  (warn_th_q),
      .alarm_th (alarm_th_q),
      .zone_nxt (zone_nx)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      num_d        = num_q;
      sum_d        = sum_q;
      warn_th_d    = warn_th_q;
      alarm_th_d   = alarm_th_q;
      temp_avg_d   = temp_avg_q;
      temp_valid_d = 1'b0;
      zone_d       = zone_q;

      case (state_q)
         WAIT: begin
            if (enable) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = REQ;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         REQ: begin
            if (hs) begin
               sum_d   = sum_q + SW'(conv_out);
               num_d   = num_q + 1'b1;
               state_d = (num_d == N_FULL) ? EVAL : WAIT;
            end
         end
         EVAL: begin
            temp_avg_d   = avg_new;
            temp_valid_d = 1'b1;
            zone_d       = zone_nx;
            sum_d        = '0;
            num_d        = '0;
            state_d      = WAIT;
         end
         default: state_d = WAIT;
      endcase

      // Config applied last so a clear overrides a same-cycle handshake
      if (bus.cfg_we) begin
         case (bus.cfg_addr)
            CFG_WARN:  warn_th_d  = bus.cfg_wdata;
            CFG_ALARM: alarm_th_d = bus.cfg_wdata;
            CFG_CLEAR: begin
               sum_d   = '0;
               num_d   = '0;
               cnt_d   = '0;
               state_d = WAIT;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= WAIT;
         cnt_q        <= '0;
         num_q        <= '0;
         sum_q        <= '0;
         warn_th_q    <= WARN_TH_RST;
         alarm_th_q   <= ALARM_TH_RST;
         temp_avg_q   <= '0;
         temp_valid_q <= 1'b0;
         zone_q       <= ZONE_NORMAL;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         num_q        <= num_d;
         sum_q        <= sum_d;
         warn_th_q    <= warn_th_d;
         alarm_th_q   <= alarm_th_d;
         temp_avg_q   <= temp_avg_d;
         temp_valid_q <= temp_valid_d;
         zone_q       <= zone_d;
      end
   end

   assign temp_valid = temp_valid_q;
   assign temp_avg   = temp_avg_q;
   assign zone       = zone_q;
   assign warn       = (zone_q == ZONE_WARN);
   assign alarm      = (zone_q == ZONE_ALARM);

endmodule

// File: tb/tb_temperature_ctrl.sv
// Directed bench for temperature_ctrl: sensor feed with a scoreboard of
// expected averages/zones, reset, config, enable-hold and clear scenarios.
module tb_temperature_ctrl;
   import temperature_pkg::*;

   localparam int unsigned P = 4;

   typedef struct {
      logic [7:0] avg;
      logic [1:0] zone;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic [7:0] conv_in;
   logic [7:0] conv_out;
   logic       temp_valid;
   logic [7:0] temp_avg;
   logic [1:0] zone;
   logic       warn;
   logic       alarm;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   temperature_ctrl_if bus();

   assign conv_out = conv_in;

   temperature_ctrl #(
      .SAMPLE_PERIOD (P),
      .AVG_LOG2      (2),
      .HYST          (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .bus        (bus),
      .conv_in    (conv_in),
      .conv_out   (conv_out),
      .temp_valid (temp_valid),
      .temp_avg   (temp_avg),
      .zone       (zone),
      .warn       (warn),
      .alarm      (alarm)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for raw_ready at a negedge, presents d for the handshake edge
   task automatic feed(input logic [7:0] d, input int exp_gap);
      int n;
      n = 0;
      while (bus.raw_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("ready_seen", 32'(bus.raw_ready), 32'd1);
      if (exp_gap >= 0) chk("ready_gap", 32'(n), 32'(exp_gap));
      bus.raw_data = d;
      @(negedge clk);
      chk("ready_drop", 32'(bus.raw_ready), 32'd0);
   endtask

   task automatic expect_avg(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d, input logic [1:0] z);
      logic [9:0] s;
      exp_t       e;
      s      = 10'(a) + 10'(b) + 10'(c) + 10'(d);
      e.avg  = s[9:2];
      e.zone = z;
      sb.push_back(e);
   endtask

   task automatic wait_result(input string tag);
      int   n;
      exp_t e;
      n = 0;
      while (temp_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, 32'(temp_valid), 32'd1);
      e = sb.pop_front();
      chk({tag, "_avg"},   32'(temp_avg), 32'(e.avg));
      chk({tag, "_zone"},  32'(zone),     32'(e.zone));
      chk({tag, "_warn"},  32'(warn),     32'(e.zone == 2'd1));
      chk({tag, "_alarm"}, 32'(alarm),    32'(e.zone == 2'd2));
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(temp_valid), 32'd0);
   endtask

   task automatic batch(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d, input logic [1:0] z, input int g0, input string tag);
      expect_avg(a, b, c, d, z);
      feed(a, g0);
      feed(b, int'(P));
      feed(c, int'(P));
      feed(d, int'(P));
      wait_result(tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(bus.raw_ready), 32'd0);
      chk({tag, "_valid"}, 32'(temp_valid),    32'd0);
      chk({tag, "_avg"},   32'(temp_avg),      32'd0);
      chk({tag, "_zone"},  32'(zone),          32'd0);
      chk({tag, "_warn"},  32'(warn),          32'd0);
      chk({tag, "_alarm"}, 32'(alarm),         32'd0);
   endtask

   initial begin
      int n;
      int hi;
      bus.raw_valid = 1'b0;
      bus.raw_data  = 8'd0;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = 2'd0;
      bus.cfg_wdata = 8'd0;

      repeat (3) @(negedge clk);
      check_reset_outputs("rst0");
      rst_n         = 1'b1;
      enable        = 1'b1;
      bus.raw_valid = 1'b1;

      // basic average, ready spacing
      batch(8'd10, 8'd20, 8'd30, 8'd40, 2'd0, int'(P), "t1");

      // direct jump to ALARM, hold inside hysteresis, fall to WARN
      batch(8'd84, 8'd86, 8'd85, 8'd86, 2'd2, -1, "t2_85");
      batch(8'd79, 8'd79, 8'd79, 8'd79, 2'd2, -1, "t2_79");
      batch(8'd77, 8'd77, 8'd77, 8'd77, 2'd1, -1, "t2_77");

      // WARN hysteresis
      batch(8'd58, 8'd60, 8'd59, 8'd59, 2'd1, -1, "t3_59");
      batch(8'd56, 8'd58, 8'd57, 8'd57, 2'd0, -1, "t3_57");

      // reset in REQ after two samples drops the partial average
      feed(8'd100, -1);
      feed(8'd100, int'(P));
      n = 0;
      while (bus.raw_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t4_req", 32'(bus.raw_ready), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("t4_rst");
      rst_n = 1'b1;
      batch(8'd8, 8'd8, 8'd8, 8'd8, 2'd0, int'(P), "t4_fresh");

      // threshold write during EVAL uses the old warn_th
      expect_avg(8'd40, 8'd40, 8'd40, 8'd40, 2'd0);
      feed(8'd40, -1);
      feed(8'd40, int'(P));
      feed(8'd40, int'(P));
      feed(8'd40, int'(P));
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = CFG_WARN;
      bus.cfg_wdata = 8'd30;
      @(negedge clk);
      bus.cfg_we = 1'b0;
      wait_result("t5_old");
      batch(8'd40, 8'd40, 8'd40, 8'd40, 2'd1, -1, "t5_new");

      // enable hold mid-WAIT, then clear colliding with a handshake
      feed(8'd100, -1);
      repeat (2) @(negedge clk);
      enable = 1'b0;
      hi = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.raw_ready !== 1'b0) hi++;
      end
      chk("t6_hold_ready", 32'(hi), 32'd0);
      enable = 1'b1;
      n = 0;
      while (bus.raw_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t6_resume_gap", 32'(n), 32'd2);
      bus.raw_data  = 8'd200;
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = CFG_CLEAR;
      bus.cfg_wdata = 8'd0;
      @(negedge clk);
      bus.cfg_we = 1'b0;
      chk("t6_clear_ready", 32'(bus.raw_ready), 32'd0);
      batch(8'd12, 8'd16, 8'd20, 8'd24, 2'd0, int'(P), "t6_after_clear");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
